// File: rtl/axi_pkg.sv
// Shared AXI definitions for the memory-slave responders.
// Contents:
//   burst_t    - AXI burst encoding (FIXED/INCR/WRAP/RSVD)
//   resp_t     - AXI response encoding (OKAY/EXOKAY/SLVERR/DECERR)
//   rd_state_t - read responder FSM states (IDLE/READ/DATA)
//   SIZE_WORD  - the only supported transfer size (4 bytes)
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DATA = 2'b10
  } rd_state_t;

  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address generator for word-sized beats.
// Ports:
//   addr      in  32  current beat byte address
//   len       in  4   burst length minus one
//   burst     in  2   burst type
//   next_addr out 32  byte address of the following beat
// WRAP keeps the bits above the wrap boundary and increments only the
// bits inside it; the wrap window is (len+1) words. RSVD holds the
// address (such bursts are errored and never reach memory anyway).
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [3:0]  len,
  input  burst_t      burst,
  output logic [31:0] next_addr
);

  logic [31:0] beats;
  logic [31:0] wrap_mask;
  logic [31:0] incr_addr;

  assign beats     = {28'd0, len} + 32'd1;
  assign wrap_mask = (beats << 2) - 32'd1;
  assign incr_addr = addr + 32'd4;

  always_comb begin
    next_addr = addr;
    case (burst)
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// Slave-side AXI read responder for a single-port synchronous SRAM.
// One AR request at a time; returns ARLEN+1 beats on R with RID/RRESP/RLAST,
// one beat per cycle while RREADY_S is high.
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   AR*_S                  read address channel (slave side)
//   R*_S                   read data channel (slave side)
//   mem_en/mem_addr        SRAM read enable and word address
//   mem_rdata              SRAM read data, valid the cycle after mem_en
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int MEM_AW = 14
)
(
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [7:0]        ARID_S,
  input  logic [31:0]       ARADDR_S,
  input  logic [3:0]        ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [7:0]        RID_S,
  output logic [31:0]       RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  rd_state_t   state_reg, state_next;
  logic        rst_done_reg;
  logic [7:0]  id_reg;
  logic [31:0] addr_reg;
  logic [3:0]  len_reg;
  logic [3:0]  beat_reg;
  burst_t      burst_reg;
  logic        err_reg;

  logic [31:0] next_addr;
  logic        req_err;
  logic        wrap_len_ok;
  logic        ar_hs;
  logic        advance;

  axi_burst_addr_gen u_addr_gen (
    .addr      (addr_reg),
    .len       (len_reg),
    .burst     (burst_reg),
    .next_addr (next_addr)
  );

  // Wrapping bursts must cover a power-of-two window of 2, 4, 8 or 16 beats.
  assign wrap_len_ok = (ARLEN_S == 4'd1) || (ARLEN_S == 4'd3) ||
                       (ARLEN_S == 4'd7) || (ARLEN_S == 4'd15);
  assign req_err = (ARSIZE_S != SIZE_WORD) ||
                   (ARBURST_S == 2'b11) ||
                   ((ARBURST_S == 2'b10) && !wrap_len_ok);

  assign ar_hs = ARVALID_S && ARREADY_S;
  assign RID_S = id_reg;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ARREADY_S  = 1'b0;
    RVALID_S   = 1'b0;
    RLAST_S    = 1'b0;
    RRESP_S    = OKAY;
    RDATA_S    = 32'd0;
    mem_en     = 1'b0;
    mem_addr   = addr_reg[MEM_AW+1:2];
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Hold off requests for the first cycle out of reset.
        ARREADY_S = rst_done_reg;
        if (ARVALID_S && rst_done_reg) begin
          state_next = READ;
        end
      end
      READ: begin
        mem_en     = !err_reg;
        state_next = DATA;
      end
      DATA: begin
        RVALID_S = 1'b1;
        RLAST_S  = (beat_reg == len_reg);
        RRESP_S  = err_reg ? SLVERR : OKAY;
        RDATA_S  = err_reg ? 32'd0 : mem_rdata;
        if (RREADY_S) begin
          if (beat_reg == len_reg) begin
            state_next = IDLE;
          end else begin
            // Prefetch the next beat so it is ready the following cycle.
            advance  = 1'b1;
            mem_en   = !err_reg;
            mem_addr = next_addr[MEM_AW+1:2];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rst_done_reg <= 1'b0;
      id_reg       <= 8'd0;
      addr_reg     <= 32'd0;
      len_reg      <= 4'd0;
      beat_reg     <= 4'd0;
      burst_reg    <= FIXED;
      err_reg      <= 1'b0;
    end else begin
      rst_done_reg <= 1'b1;
      if (ar_hs) begin
        id_reg    <= ARID_S;
        addr_reg  <= ARADDR_S;
        len_reg   <= ARLEN_S;
        burst_reg <= burst_t'(ARBURST_S);
        err_reg   <= req_err;
        beat_reg  <= 4'd0;
      end else if (advance) begin
        beat_reg <= beat_reg + 4'd1;
        addr_reg <= next_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed testbench for axi_read_responder with a behavioural SRAM whose
// word at address a holds 32'hC0DE_0000 | a.
module tb_axi_read_responder;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  ARID_S = '0;
  logic [31:0] ARADDR_S = '0;
  logic [3:0]  ARLEN_S = '0;
  logic [2:0]  ARSIZE_S = 3'b010;
  logic [1:0]  ARBURST_S = 2'b01;
  logic        ARVALID_S = 1'b0;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S = 1'b0;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_mis = 0;
  logic [13:0] exp_wa [16];

  always #5 ACLK = ~ACLK;

  axi_read_responder #(.MEM_AW(14)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARID_S    (ARID_S),
    .ARADDR_S  (ARADDR_S),
    .ARLEN_S   (ARLEN_S),
    .ARSIZE_S  (ARSIZE_S),
    .ARBURST_S (ARBURST_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always @(posedge ACLK) begin
    if (mem_en) mem_rdata <= 32'hC0DE_0000 | {18'd0, mem_addr};
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request and walks the whole burst; exp_wa holds the
  // hand-computed word addresses. Optional stall of stall_n cycles on beat stall_beat.
  task automatic run_burst(input string name, input logic [7:0] id, input logic [31:0] a,
                           input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                           input logic err, input int stall_beat, input int stall_n);
    int t;
    logic [31:0] exp_data;
    @(negedge ACLK);
    ARID_S = id; ARADDR_S = a; ARLEN_S = len; ARSIZE_S = sz; ARBURST_S = bu;
    ARVALID_S = 1'b1; RREADY_S = 1'b1;
    t = 0;
    while (!ARREADY_S && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    check_vec({name, " arready"}, ARREADY_S, 1);
    @(posedge ACLK);
    #1 ARVALID_S = 1'b0;
    @(negedge ACLK);
    check_vec({name, " read_rvalid"}, RVALID_S, 0);
    check_vec({name, " read_mem_en"}, mem_en, !err);
    if (!err) check_vec({name, " read_addr"}, mem_addr, exp_wa[0]);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge ACLK);
      exp_data = err ? 32'd0 : (32'hC0DE_0000 | {18'd0, exp_wa[i]});
      if (i == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          RREADY_S = 1'b0;
          #1;
          check_vec($sformatf("%s stall%0d rvalid", name, s), RVALID_S, 1);
          check_vec($sformatf("%s stall%0d rdata", name, s), RDATA_S, exp_data);
          check_vec($sformatf("%s stall%0d rid", name, s), RID_S, {24'd0, id});
          check_vec($sformatf("%s stall%0d rlast", name, s), RLAST_S, (i == int'(len)));
          check_vec($sformatf("%s stall%0d mem_en", name, s), mem_en, 0);
          @(negedge ACLK);
        end
      end
      RREADY_S = 1'b1;
      #1;
      check_vec($sformatf("%s b%0d rvalid", name, i), RVALID_S, 1);
      check_vec($sformatf("%s b%0d rdata", name, i), RDATA_S, exp_data);
      check_vec($sformatf("%s b%0d rid", name, i), RID_S, {24'd0, id});
      check_vec($sformatf("%s b%0d rresp", name, i), RRESP_S, err ? 2'b10 : 2'b00);
      check_vec($sformatf("%s b%0d rlast", name, i), RLAST_S, (i == int'(len)));
      if (i < int'(len)) begin
        check_vec($sformatf("%s b%0d mem_en", name, i), mem_en, !err);
        if (!err) check_vec($sformatf("%s b%0d mem_addr", name, i), mem_addr, exp_wa[i+1]);
      end else begin
        check_vec($sformatf("%s b%0d mem_en", name, i), mem_en, 0);
      end
    end
    @(negedge ACLK);
    #1;
    check_vec({name, " post_rvalid"}, RVALID_S, 0);
    check_vec({name, " post_arready"}, ARREADY_S, 1);
    $display("burst %s id=%h addr=%h len=%0d done", name, id, a, len);
  endtask

  initial begin
    // Reset state
    #2;
    check_vec("rst arready", ARREADY_S, 0);
    check_vec("rst rvalid", RVALID_S, 0);
    check_vec("rst rlast", RLAST_S, 0);
    check_vec("rst rid", RID_S, 0);
    check_vec("rst rresp", RRESP_S, 0);
    check_vec("rst rdata", RDATA_S, 0);
    check_vec("rst mem_en", mem_en, 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    #1 check_vec("rst_done arready0", ARREADY_S, 0);
    @(negedge ACLK);
    #1 check_vec("rst_done arready1", ARREADY_S, 1);

    exp_wa[0] = 14'h4;
    run_burst("single", 8'h05, 32'h0000_0010, 4'd0, 3'b010, 2'b01, 1'b0, -1, 0);

    exp_wa[0] = 14'h40; exp_wa[1] = 14'h41; exp_wa[2] = 14'h42; exp_wa[3] = 14'h43;
    run_burst("incr", 8'h11, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 1'b0, -1, 0);

    exp_wa[0] = 14'h3; exp_wa[1] = 14'h0; exp_wa[2] = 14'h1; exp_wa[3] = 14'h2;
    run_burst("wrap", 8'h22, 32'h0000_000C, 4'd3, 3'b010, 2'b10, 1'b0, -1, 0);

    exp_wa[0] = 14'h8; exp_wa[1] = 14'h8; exp_wa[2] = 14'h8;
    run_burst("fixed", 8'h33, 32'h0000_0020, 4'd2, 3'b010, 2'b00, 1'b0, -1, 0);

    exp_wa[0] = 14'h80; exp_wa[1] = 14'h81;
    run_burst("stall", 8'h44, 32'h0000_0200, 4'd1, 3'b010, 2'b01, 1'b0, 0, 3);

    run_burst("err_size", 8'h55, 32'h0000_0300, 4'd2, 3'b001, 2'b01, 1'b1, -1, 0);
    run_burst("err_rsvd", 8'h66, 32'h0000_0300, 4'd2, 3'b010, 2'b11, 1'b1, -1, 0);
    run_burst("err_wraplen", 8'h67, 32'h0000_0300, 4'd2, 3'b010, 2'b10, 1'b1, -1, 0);

    // Reset in the middle of an 8-beat burst
    @(negedge ACLK);
    ARID_S = 8'h77; ARADDR_S = 32'h0; ARLEN_S = 4'd7; ARSIZE_S = 3'b010; ARBURST_S = 2'b01;
    ARVALID_S = 1'b1; RREADY_S = 1'b1;
    #1 check_vec("midrst arready", ARREADY_S, 1);
    @(posedge ACLK);
    #1 ARVALID_S = 1'b0;
    repeat (4) @(negedge ACLK);
    #1;
    check_vec("midrst beat2 rvalid", RVALID_S, 1);
    check_vec("midrst beat2 rdata", RDATA_S, 32'hC0DE_0002);
    ARESETn = 1'b0;
    #1;
    check_vec("midrst rvalid_drop", RVALID_S, 0);
    check_vec("midrst mem_en", mem_en, 0);
    check_vec("midrst arready", ARREADY_S, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1 check_vec("midrst release arready0", ARREADY_S, 0);
    @(negedge ACLK);
    #1 check_vec("midrst release arready1", ARREADY_S, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      check_vec($sformatf("midrst residual rvalid%0d", k), RVALID_S, 0);
    end
    $display("burst midrst id=77 aborted by reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
